// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the 16-entry FIFO and its pointer counters.
package fifo_pkg;

    localparam int unsigned FIFO_PTR_W  = 5;
    localparam int unsigned FIFO_ADDR_W = 4;
    localparam int unsigned FIFO_DEPTH  = 16;

    localparam logic [FIFO_PTR_W-1:0] PTR_RESET_VAL = 5'd0;

    // Binary to reflected Gray code.
    function automatic logic [FIFO_PTR_W-1:0] bin2gray(input logic [FIFO_PTR_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/Mux_2_1_5b.sv
// 5-bit two-input multiplexer: Out = Select ? In_1 : In_0.
module Mux_2_1_5b
    import fifo_pkg::*;
(
    input  logic [FIFO_PTR_W-1:0] In_0,
    input  logic [FIFO_PTR_W-1:0] In_1,
    input  logic                  Select,
    output logic [FIFO_PTR_W-1:0] Out
);

    assign Out = Select ? In_1 : In_0;

endmodule

// File: rtl/dff_5b_ar.sv
// 5-bit D register with asynchronous active-low reset to a supplied reset value.
module dff_5b_ar
    import fifo_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_PTR_W-1:0] i_rst_val,
    input  logic [FIFO_PTR_W-1:0] i_d,
    output logic [FIFO_PTR_W-1:0] o_q
);

    logic [FIFO_PTR_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= i_rst_val;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fifo_ptr_counter_5b.sv
// FIFO read/write pointer: binary count with Clear > Load > Enable priority,
// registered Gray copy for the full/empty compare, and a one-cycle wrap pulse.
module fifo_ptr_counter_5b
    import fifo_pkg::*;
#(
    parameter int unsigned           PTR_W     = FIFO_PTR_W,
    parameter logic [PTR_W-1:0]      RESET_VAL = PTR_RESET_VAL
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Enable,
    input  logic             Clear,
    input  logic             Load,
    input  logic [PTR_W-1:0] Load_value,
    output logic [PTR_W-1:0] Ptr_bin,
    output logic [PTR_W-1:0] Ptr_gray,
    output logic [PTR_W-2:0] Addr,
    output logic             Wrap_bit,
    output logic             Wrap_pulse
);

    localparam logic [PTR_W-1:0] RESET_GRAY = RESET_VAL ^ (RESET_VAL >> 1);

    logic [PTR_W-1:0] w_ptr_bin;
    logic [PTR_W-1:0] w_ptr_gray;
    logic [PTR_W-1:0] w_inc;
    logic [PTR_W-1:0] w_carry;
    logic [PTR_W-1:0] w_mux_en;
    logic [PTR_W-1:0] w_mux_ld;
    logic [PTR_W-1:0] w_next;
    logic [PTR_W-1:0] w_next_gray;
    logic             w_wrap_evt;
    logic             r_wrap_pulse;

    // Ripple incrementer: half-adder chain with carry-in forced to 1.
    assign w_carry[0] = 1'b1;
    for (genvar i = 0; i < PTR_W; i++) begin : g_inc
        assign w_inc[i] = w_ptr_bin[i] ^ w_carry[i];
        if (i < PTR_W - 1) begin : g_carry
            assign w_carry[i+1] = w_ptr_bin[i] & w_carry[i];
        end
    end

    Mux_2_1_5b u_mux_en (
        .In_0   (w_ptr_bin),
        .In_1   (w_inc),
        .Select (Enable),
        .Out    (w_mux_en)
    );

    Mux_2_1_5b u_mux_ld (
        .In_0   (w_mux_en),
        .In_1   (Load_value),
        .Select (Load),
        .Out    (w_mux_ld)
    );

    Mux_2_1_5b u_mux_clr (
        .In_0   (w_mux_ld),
        .In_1   (RESET_VAL),
        .Select (Clear),
        .Out    (w_next)
    );

    // Gray is computed from next-state so both registers share alignment.
    assign w_next_gray = w_next ^ (w_next >> 1);

    dff_5b_ar u_reg_bin (
        .clk       (Clock),
        .rst_n     (Reset_n),
        .i_rst_val (RESET_VAL),
        .i_d       (w_next),
        .o_q       (w_ptr_bin)
    );

    dff_5b_ar u_reg_gray (
        .clk       (Clock),
        .rst_n     (Reset_n),
        .i_rst_val (RESET_GRAY),
        .i_d       (w_next_gray),
        .o_q       (w_ptr_gray)
    );

    // Only a genuine 31->0 increment counts as a wrap; Clear/Load never do.
    assign w_wrap_evt = Enable & ~Clear & ~Load & (&w_ptr_bin);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wrap_pulse <= 1'b0;
        end else begin
            r_wrap_pulse <= w_wrap_evt;
        end
    end

    assign Ptr_bin    = w_ptr_bin;
    assign Ptr_gray   = w_ptr_gray;
    assign Addr       = w_ptr_bin[PTR_W-2:0];
    assign Wrap_bit   = w_ptr_bin[PTR_W-1];
    assign Wrap_pulse = r_wrap_pulse;

endmodule

// File: tb/tb_fifo_ptr_counter_5b.sv
// Self-checking bench for fifo_ptr_counter_5b against an arithmetic pointer model.
module tb_fifo_ptr_counter_5b;

    logic       Clock;
    logic       Reset_n;
    logic       Enable;
    logic       Clear;
    logic       Load;
    logic [4:0] Load_value;
    logic [4:0] Ptr_bin;
    logic [4:0] Ptr_gray;
    logic [3:0] Addr;
    logic       Wrap_bit;
    logic       Wrap_pulse;

    int checks;
    int failures;
    int m_ptr;
    bit m_wrap;

    fifo_ptr_counter_5b dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Enable     (Enable),
        .Clear      (Clear),
        .Load       (Load),
        .Load_value (Load_value),
        .Ptr_bin    (Ptr_bin),
        .Ptr_gray   (Ptr_gray),
        .Addr       (Addr),
        .Wrap_bit   (Wrap_bit),
        .Wrap_pulse (Wrap_pulse)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Drive one cycle of controls, advance the model, return #1 after the edge.
    task automatic apply_cycle(input bit en, input bit clr, input bit ld, input logic [4:0] lv);
        Enable = en; Clear = clr; Load = ld; Load_value = lv;
        m_wrap = en && !clr && !ld && (m_ptr == 31);
        if (clr)      m_ptr = 0;
        else if (ld)  m_ptr = int'(lv);
        else if (en)  m_ptr = (m_ptr + 1) % 32;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; Enable = 0; Clear = 0; Load = 0; Load_value = '0;
        m_ptr = 0; m_wrap = 0;
        #1;
        checks++;
        if (Ptr_bin !== 5'd0 || Ptr_gray !== 5'd0 || Wrap_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: bin=%h gray=%h pulse=%b expected 00 00 0", Ptr_bin, Ptr_gray, Wrap_pulse);
        end
        @(negedge Clock);
        Reset_n = 1'b1;
        @(posedge Clock);
        #1;
        checks++;
        if (Ptr_bin !== 5'd0) begin
            failures++;
            $display("FAIL reset_hold: bin=%h expected 00", Ptr_bin);
        end
    endtask

    task automatic test_count33();
        logic [4:0] eb;
        logic [4:0] eg;
        apply_cycle(0, 1, 0, 5'd0);
        for (int i = 0; i < 33; i++) begin
            apply_cycle(1, 0, 0, 5'd0);
            eb = 5'((i + 1) % 32);
            eg = 5'(int'(eb) ^ (int'(eb) / 2));
            checks++;
            if (Ptr_bin !== eb || Ptr_gray !== eg || Wrap_pulse !== (eb == 5'd0)) begin
                failures++;
                $display("FAIL count33[%0d]: bin=%h gray=%h pulse=%b expected %h %h %b",
                         i, Ptr_bin, Ptr_gray, Wrap_pulse, eb, eg, (eb == 5'd0));
            end
        end
    endtask

    task automatic test_load_wrap();
        logic [4:0] exp_seq [4];
        logic       exp_pls [4];
        exp_seq[0] = 5'd30; exp_seq[1] = 5'd31; exp_seq[2] = 5'd0; exp_seq[3] = 5'd1;
        exp_pls[0] = 1'b0;  exp_pls[1] = 1'b0;  exp_pls[2] = 1'b1; exp_pls[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) apply_cycle(0, 0, 1, 5'd30);
            else        apply_cycle(1, 0, 0, 5'd0);
            checks++;
            if (Ptr_bin !== exp_seq[i] || Wrap_pulse !== exp_pls[i]) begin
                failures++;
                $display("FAIL load_wrap[%0d]: bin=%h pulse=%b expected %h %b",
                         i, Ptr_bin, Wrap_pulse, exp_seq[i], exp_pls[i]);
            end
        end
    endtask

    task automatic test_priority();
        apply_cycle(0, 0, 1, 5'd31);
        checks++;
        if (Ptr_bin !== 5'd31) begin
            failures++;
            $display("FAIL prio_load31: bin=%h expected 1f", Ptr_bin);
        end
        apply_cycle(1, 1, 1, 5'd17);
        checks++;
        if (Ptr_bin !== 5'd0 || Ptr_gray !== 5'd0 || Wrap_pulse !== 1'b0) begin
            failures++;
            $display("FAIL prio_all3: bin=%h gray=%h pulse=%b expected 00 00 0", Ptr_bin, Ptr_gray, Wrap_pulse);
        end
        apply_cycle(0, 0, 1, 5'd31);
        apply_cycle(1, 0, 1, 5'd0);
        checks++;
        if (Ptr_bin !== 5'd0 || Wrap_pulse !== 1'b0) begin
            failures++;
            $display("FAIL prio_load0_at31: bin=%h pulse=%b expected 00 0", Ptr_bin, Wrap_pulse);
        end
        apply_cycle(1, 0, 1, 5'd9);
        checks++;
        if (Ptr_bin !== 5'd9 || Ptr_gray !== 5'd13) begin
            failures++;
            $display("FAIL prio_load_over_en: bin=%h gray=%h expected 09 0d", Ptr_bin, Ptr_gray);
        end
    endtask

    task automatic test_reset_mid();
        apply_cycle(0, 1, 0, 5'd0);
        for (int i = 0; i < 13; i++) apply_cycle(1, 0, 0, 5'd0);
        checks++;
        if (Ptr_bin !== 5'd13) begin
            failures++;
            $display("FAIL reset_mid_pre: bin=%h expected 0d", Ptr_bin);
        end
        Enable = 0; Clear = 0; Load = 0;
        Reset_n = 1'b0;
        m_ptr = 0; m_wrap = 0;
        #1;
        checks++;
        if (Ptr_bin !== 5'd0 || Ptr_gray !== 5'd0 || Wrap_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async: bin=%h gray=%h pulse=%b expected 00 00 0", Ptr_bin, Ptr_gray, Wrap_pulse);
        end
        #2;
        Reset_n = 1'b1;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_random();
        bit         en;
        bit         clr;
        bit         ld;
        logic [4:0] lv;
        logic [4:0] eb;
        for (int i = 0; i < 200; i++) begin
            en  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 24) == 0);
            ld  = ($urandom_range(0, 19) == 0);
            lv  = 5'($urandom);
            apply_cycle(en, clr, ld, lv);
            eb = 5'(m_ptr);
            checks++;
            if (Ptr_bin !== eb || Ptr_gray !== (eb ^ (eb >> 1)) || Wrap_pulse !== m_wrap
                || Addr !== eb[3:0] || Wrap_bit !== eb[4]) begin
                failures++;
                $display("FAIL random[%0d]: bin=%h gray=%h pulse=%b addr=%h wb=%b expected bin=%h pulse=%b",
                         i, Ptr_bin, Ptr_gray, Wrap_pulse, Addr, Wrap_bit, eb, m_wrap);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_count33();
        test_load_wrap();
        test_priority();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
